// File: rtl/rx_mac_hash_calc.sv
// rx_mac_hash_calc: assembles DMAC/SMAC byte streams into 48-bit addresses,
// folds each into a hash index, classifies the DMAC and queues the results
// (2 entries) toward the MAC-table lookup engine.

// One address collector: IDLE -> COLLECT -> DONE, six bytes MSB first.
module rx_mac_collector (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  data_i,
  input  logic        vld_i,
  input  logic        soc_i,
  input  logic        eoc_i,
  input  logic        pair_i,
  input  logic        flush_i,
  output logic        done_o,
  output logic [47:0] addr_o,
  output logic        err_o,
  output logic        desync_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic [47:0] addr_q, addr_d;

  assign done_o   = (state_q == DONE);
  assign addr_o   = addr_q;
  assign desync_o = done_o & vld_i & soc_i & ~pair_i;
  assign cnt_inc  = cnt_q + 3'd1;

  // State, byte counter and shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: field framing, length checking and desync detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_o   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (vld_i && soc_i) begin
            if (eoc_i) begin
              err_o = 1'b1;
            end else begin
              addr_d  = {40'd0, data_i};
              cnt_d   = 3'd1;
              state_d = COLLECT;
            end
          end
        end
        COLLECT: begin
          if (vld_i) begin
            if (soc_i) begin
              err_o = 1'b1;
              if (eoc_i) begin
                state_d = IDLE;
              end else begin
                addr_d = {40'd0, data_i};
                cnt_d  = 3'd1;
              end
            end else begin
              addr_d = {addr_q[39:0], data_i};
              cnt_d  = cnt_inc;
              if (eoc_i) begin
                if (cnt_inc == 3'd6) begin
                  state_d = DONE;
                end else begin
                  err_o   = 1'b1;
                  state_d = IDLE;
                end
              end else if (cnt_inc == 3'd7) begin
                err_o   = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
        DONE: begin
          // While pairing, a soc simply starts the next field; otherwise it
          // means the partner never finished and this frame is abandoned.
          if (pair_i) begin
            state_d = IDLE;
          end
          if (vld_i && soc_i) begin
            if (eoc_i) begin
              err_o   = 1'b1;
              state_d = IDLE;
            end else begin
              err_o   = ~pair_i;
              addr_d  = {40'd0, data_i};
              cnt_d   = 3'd1;
              state_d = COLLECT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

module rx_mac_hash_calc #(
  parameter int unsigned HASH_WIDTH     = 12,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_dmac_data,
  input  logic                      i_dmac_data_vld,
  input  logic                      i_dmac_soc,
  input  logic                      i_dmac_eoc,
  input  logic [7:0]                i_smac_data,
  input  logic                      i_smac_data_vld,
  input  logic                      i_smac_soc,
  input  logic                      i_smac_eoc,
  output logic                      o_hash_vld,
  input  logic                      i_hash_ready,
  output logic [47:0]               o_dmac,
  output logic [47:0]               o_smac,
  output logic [HASH_WIDTH-1:0]     o_dmac_hash,
  output logic [HASH_WIDTH-1:0]     o_smac_hash,
  output logic                      o_broadcast_frm,
  output logic                      o_multicast_frm,
  output logic                      o_mac_err,
  output logic                      o_ovf_drop,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt
);
  localparam int unsigned NSLICE = 48 / HASH_WIDTH;

  function automatic logic [HASH_WIDTH-1:0] fold(input logic [47:0] a);
    logic [HASH_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NSLICE; i++) r ^= a[i*HASH_WIDTH +: HASH_WIDTH];
    return r;
  endfunction

  logic        d_done, s_done, d_err, s_err, d_desync, s_desync, pair;
  logic [47:0] d_addr, s_addr;

  assign pair = d_done & s_done;

  rx_mac_collector u_dmac (
    .clk_i(i_clk), .rst_ni(i_rst), .data_i(i_dmac_data), .vld_i(i_dmac_data_vld),
    .soc_i(i_dmac_soc), .eoc_i(i_dmac_eoc), .pair_i(pair), .flush_i(s_desync),
    .done_o(d_done), .addr_o(d_addr), .err_o(d_err), .desync_o(d_desync)
  );

  rx_mac_collector u_smac (
    .clk_i(i_clk), .rst_ni(i_rst), .data_i(i_smac_data), .vld_i(i_smac_data_vld),
    .soc_i(i_smac_soc), .eoc_i(i_smac_eoc), .pair_i(pair), .flush_i(d_desync),
    .done_o(s_done), .addr_o(s_addr), .err_o(s_err), .desync_o(s_desync)
  );

  logic [47:0]           dmac_mem [2];
  logic [47:0]           smac_mem [2];
  logic [HASH_WIDTH-1:0] dh_mem   [2];
  logic [HASH_WIDTH-1:0] sh_mem   [2];
  logic                  bc_mem   [2];
  logic                  mc_mem   [2];

  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic       empty, full, pop, do_push, drop, bcast;
  logic       mac_err_q, ovf_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[0] == rd_ptr_q[0]) & (wr_ptr_q[1] != rd_ptr_q[1]);
  assign pop     = ~empty & i_hash_ready;
  assign do_push = pair & (~full | pop);
  assign drop    = pair & full & ~pop;
  assign bcast   = (d_addr == '1);

  // Queue pointers, error/drop pulses and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mac_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      mac_err_q <= d_err | s_err;
      ovf_q     <= drop;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  // Entry storage: hashes and classification computed at pairing.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      dmac_mem[wr_ptr_q[0]] <= d_addr;
      smac_mem[wr_ptr_q[0]] <= s_addr;
      dh_mem[wr_ptr_q[0]]   <= fold(d_addr);
      sh_mem[wr_ptr_q[0]]   <= fold(s_addr);
      bc_mem[wr_ptr_q[0]]   <= bcast;
      mc_mem[wr_ptr_q[0]]   <= d_addr[40] & ~bcast;
    end
  end

  assign o_hash_vld      = ~empty;
  assign o_dmac          = empty ? '0 : dmac_mem[rd_ptr_q[0]];
  assign o_smac          = empty ? '0 : smac_mem[rd_ptr_q[0]];
  assign o_dmac_hash     = empty ? '0 : dh_mem[rd_ptr_q[0]];
  assign o_smac_hash     = empty ? '0 : sh_mem[rd_ptr_q[0]];
  assign o_broadcast_frm = ~empty & bc_mem[rd_ptr_q[0]];
  assign o_multicast_frm = ~empty & mc_mem[rd_ptr_q[0]];
  assign o_mac_err       = mac_err_q;
  assign o_ovf_drop      = ovf_q;
  assign o_drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_rx_mac_hash_calc.sv
// Randomized bench for rx_mac_hash_calc: frame-level reference model with a
// scoreboard of expected queue entries and expected error/drop counts.
module tb_rx_mac_hash_calc;
  localparam int unsigned HW = 12;
  localparam int unsigned DW = 4;

  logic clk, rst_n;
  logic [7:0] dd, sd;
  logic dv, ds, de, sv, ss, se, ready;
  logic hv, berr, ovf, bc, mc;
  logic [47:0] odm, osm;
  logic [HW-1:0] odh, osh;
  logic [DW-1:0] dcnt;

  rx_mac_hash_calc #(.HASH_WIDTH(HW), .DROP_CNT_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_dmac_data(dd), .i_dmac_data_vld(dv), .i_dmac_soc(ds), .i_dmac_eoc(de),
    .i_smac_data(sd), .i_smac_data_vld(sv), .i_smac_soc(ss), .i_smac_eoc(se),
    .o_hash_vld(hv), .i_hash_ready(ready), .o_dmac(odm), .o_smac(osm),
    .o_dmac_hash(odh), .o_smac_hash(osh), .o_broadcast_frm(bc), .o_multicast_frm(mc),
    .o_mac_err(berr), .o_ovf_drop(ovf), .o_drop_cnt(dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0]   d, s;
    logic [HW-1:0] dh, sh;
    logic          bc, mc;
  } ent_t;

  ent_t        sb[$];
  logic [10:0] dq[$];
  logic [10:0] sq[$];
  int n_checks = 0, n_fail = 0;
  int err_seen = 0, drop_seen = 0, pop_cnt = 0;
  int exp_err = 0, exp_drop = 0, exp_dcnt = 0;
  ent_t mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] ref_hash(input logic [47:0] a);
    logic [HW-1:0] h = '0;
    logic [47:0]   t = a;
    for (int k = 0; k < 48 / HW; k++) begin
      h ^= t[HW-1:0];
      t = t >> HW;
    end
    return h;
  endfunction

  function automatic ent_t mk(input logic [47:0] d, input logic [47:0] s);
    ent_t e;
    e.d = d; e.s = s; e.dh = ref_hash(d); e.sh = ref_hash(s);
    e.bc = (d == 48'hFFFF_FFFF_FFFF);
    e.mc = d[40] && !e.bc;
    return e;
  endfunction

  function automatic logic [47:0] rand_mac();
    logic [47:0] m = {16'($urandom), 32'($urandom)};
    int sel = $urandom_range(0, 7);
    if (sel == 0) m = '1;
    else if (sel == 1) m[40] = 1'b1;
    return m;
  endfunction

  function automatic logic [10:0] idle_word();
    return {1'b0, 1'($urandom), 1'($urandom), 8'($urandom)};
  endfunction

  task automatic add_byte(input bit is_s, input logic [10:0] w);
    if (is_s) sq.push_back(w); else dq.push_back(w);
  endtask

  task automatic add_gap(input bit is_s, input int gap);
    int g = (gap < 0) ? $urandom_range(0, 1) : gap;
    repeat (g) add_byte(is_s, idle_word());
  endtask

  // kind: 0 good, 1 eoc on 5th byte, 2 seven bytes no eoc, 3 soc+eoc single byte,
  //       4 three stray bytes then a soc restart carrying the good field
  task automatic add_field(input bit is_s, input logic [47:0] mac, input int kind,
                           input int lead, input int gap);
    int n;
    logic [47:0] t = mac;
    logic eoc;
    repeat (lead) add_byte(is_s, idle_word());
    if (kind == 4) begin
      for (int i = 0; i < 3; i++) begin
        add_byte(is_s, {1'b1, (i == 0), 1'b0, 8'($urandom)});
        add_gap(is_s, gap);
      end
    end
    n = (kind == 1) ? 5 : (kind == 2) ? 7 : (kind == 3) ? 1 : 6;
    for (int i = 0; i < n; i++) begin
      eoc = (kind != 2) && (i == n - 1);
      add_byte(is_s, {1'b1, (i == 0), eoc, t[47:40]});
      t = t << 8;
      if (i != n - 1) add_gap(is_s, gap);
    end
  endtask

  task automatic run_streams(input int tail);
    logic [10:0] w;
    while (dq.size() != 0 || sq.size() != 0) begin
      @(posedge clk); #1;
      w = (dq.size() != 0) ? dq.pop_front() : 11'd0;
      {dv, ds, de, dd} = w;
      w = (sq.size() != 0) ? sq.pop_front() : 11'd0;
      {sv, ss, se, sd} = w;
    end
    repeat (tail) begin
      @(posedge clk); #1;
      dv = 1'b0; sv = 1'b0;
    end
  endtask

  task automatic good_frame(input logic [47:0] d, input logic [47:0] s, input bit push);
    add_field(0, d, 0, $urandom_range(0, 3), -1);
    add_field(1, s, 0, $urandom_range(0, 3), -1);
    if (push) sb.push_back(mk(d, s));
    run_streams(2);
  endtask

  task automatic parallel_frame(input logic [47:0] d, input logic [47:0] s, input int tail);
    add_field(0, d, 0, 0, 0);
    add_field(1, s, 0, 0, 0);
    run_streams(tail);
  endtask

  task automatic note_drop();
    exp_drop++;
    exp_dcnt = (exp_dcnt == (1 << DW) - 1) ? exp_dcnt : exp_dcnt + 1;
  endtask

  task automatic drain();
    int k = 0;
    ready = 1'b1;
    while (k < 200 && (sb.size() != 0 || hv)) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain_left", sb.size(), 0);
    check("drain_vld", hv, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vld"}, hv, 0);
    check({tag, "_dmac"}, odm, 0);
    check({tag, "_smac"}, osm, 0);
    check({tag, "_hash"}, {odh, osh}, 0);
    check({tag, "_flags"}, {bc, mc, berr, ovf}, 0);
    check({tag, "_dcnt"}, dcnt, 0);
  endtask

  // Scoreboard pops, pulse counting.
  always @(negedge clk) begin
    if (rst_n) begin
      if (berr) err_seen++;
      if (ovf) drop_seen++;
      if (hv && ready) begin
        pop_cnt++;
        if (sb.size() == 0) check("unexpected_pop", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("dmac", odm, mon_e.d);
          check("smac", osm, mon_e.s);
          check("dmac_hash", odh, mon_e.dh);
          check("smac_hash", osh, mon_e.sh);
          check("bcast", bc, mon_e.bc);
          check("mcast", mc, mon_e.mc);
        end
      end
    end
  end

  initial begin
    logic [47:0] d, s;
    int kind, p0;
    rst_n = 1'b0; ready = 1'b1;
    dv = 0; ds = 0; de = 0; dd = 0; sv = 0; ss = 0; se = 0; sd = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Directed: interleaved streams, broadcast, multicast.
    add_field(0, 48'h0000_0000_0001, 0, 0, 1);
    add_field(1, 48'h001B_210A_0B0C, 0, 1, 1);
    sb.push_back(mk(48'h0000_0000_0001, 48'h001B_210A_0B0C));
    run_streams(3);
    good_frame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 1);
    good_frame(48'h0100_5E00_0001, 48'h0A0B_0C0D_0E0F, 1);
    drain();

    // Random well-formed frames with random gaps and offsets.
    for (int f = 0; f < 40; f++) good_frame(rand_mac(), rand_mac(), 1);
    drain();
    check("random_errs", err_seen, exp_err);

    // Malformed DMAC fields; the completed SMAC then desyncs the next frame.
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(1, 4);
      d = rand_mac(); s = rand_mac();
      add_field(0, d, kind, $urandom_range(0, 3), -1);
      add_field(1, s, 0, $urandom_range(0, 3), -1);
      exp_err++;
      if (kind == 4) sb.push_back(mk(d, s));
      run_streams(2);
      if (kind != 4) begin
        d = rand_mac(); s = rand_mac();
        add_field(1, s, 0, 0, -1);
        add_field(0, d, 0, $urandom_range(1, 2), -1);
        exp_err++;
        sb.push_back(mk(d, s));
        run_streams(2);
      end
    end
    drain();
    check("malformed_errs", err_seen, exp_err);

    // Backpressure: two held, third dropped.
    ready = 1'b0;
    good_frame(rand_mac(), rand_mac(), 1);
    good_frame(rand_mac(), rand_mac(), 1);
    good_frame(rand_mac(), rand_mac(), 0);
    note_drop();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_vld", hv, 1);
      check("hold_dmac", odm, sb[0].d);
      check("hold_smac", osm, sb[0].s);
    end
    check("bp_drops", drop_seen, exp_drop);
    check("bp_dcnt", dcnt, exp_dcnt);
    drain();

    // Full queue with push and pop in the same cycle.
    ready = 1'b0;
    good_frame(rand_mac(), rand_mac(), 1);
    good_frame(rand_mac(), rand_mac(), 1);
    d = rand_mac(); s = rand_mac();
    sb.push_back(mk(d, s));
    parallel_frame(d, s, 0);
    @(posedge clk); #1; dv = 1'b0; sv = 1'b0; ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("pp_drops", drop_seen, exp_drop);
    check("pp_vld", hv, 1);
    check("pp_head", odm, sb[0].d);
    p0 = pop_cnt;
    drain();
    check("pp_occupancy", pop_cnt - p0, 2);

    // Drop counter saturation.
    ready = 1'b0;
    good_frame(rand_mac(), rand_mac(), 1);
    good_frame(rand_mac(), rand_mac(), 1);
    for (int f = 0; f < 18; f++) begin
      parallel_frame(rand_mac(), rand_mac(), 1);
      note_drop();
    end
    repeat (3) @(negedge clk);
    check("sat_drops", drop_seen, exp_drop);
    check("sat_dcnt", dcnt, exp_dcnt);
    drain();
    check("total_errs", err_seen, exp_err);

    // Reset mid-queue and mid-DMAC field.
    ready = 1'b0;
    good_frame(rand_mac(), rand_mac(), 1);
    good_frame(rand_mac(), rand_mac(), 1);
    for (int i = 0; i < 3; i++) dq.push_back({1'b1, (i == 0), 1'b0, 8'($urandom)});
    run_streams(0);
    #3 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    sb.delete();
    exp_dcnt = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("held_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) dq.push_back({1'b1, 1'b0, (i == 2), 8'($urandom)});
    for (int i = 0; i < 4; i++) sq.push_back({1'b1, 1'b0, (i == 3), 8'($urandom)});
    run_streams(2);
    ready = 1'b1;
    good_frame(rand_mac(), rand_mac(), 1);
    drain();
    check("post_rst_errs", err_seen, exp_err);
    check("post_rst_dcnt", dcnt, exp_dcnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
